// File: rtl/sync_counter_pkg.sv
// rtl/sync_counter_pkg.sv - shared constants and helpers for the counter family
package sync_counter_pkg;

  localparam int MODE_WRAP     = 0;
  localparam int MODE_SATURATE = 1;

  // Prescaler register width; a PRESCALE of 1 or 2 still needs one bit.
  function automatic int prescale_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/enable_prescaler.sv
// rtl/enable_prescaler.sv - divides a count enable by PRESCALE enabled cycles
module enable_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en,
  output logic step
);
  import sync_counter_pkg::*;

  localparam int            PW   = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] ps_q, ps_d;

  assign step = en & (ps_q == LAST);

  always_comb begin
    ps_d = ps_q;
    if (clr_i) begin
      ps_d = '0;
    end else if (step) begin
      ps_d = '0;
    end else if (en) begin
      ps_d = ps_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

endmodule

// File: rtl/sync_updown_counter_mod.sv
// rtl/sync_updown_counter_mod.sv - modulo-N up/down counter with load, prescaler and flags
module sync_updown_counter_mod #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             carry,
  output logic             wrap,
  output logic             ovf,
  output logic             load_err
);
  import sync_counter_pkg::*;

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("sync_updown_counter_mod: MODULUS out of range for WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("sync_updown_counter_mod: PRESCALE must be at least 1");
  end
  if (SATURATE != MODE_WRAP && SATURATE != MODE_SATURATE) begin : g_bad_mode
    $error("sync_updown_counter_mod: SATURATE must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable in the load check.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             lerr_q, lerr_d;
  logic             step;

  enable_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr_i(clr | load),
    .en   (en),
    .step (step)
  );

  assign tc    = up ? (count_q == MAX_VAL) : (count_q == '0);
  assign carry = step & tc;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    wrap_d  = 1'b0;
    lerr_d  = 1'b0;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      if ({1'b0, load_val} < MOD_EXT) begin
        count_d = load_val;
      end else begin
        count_d = '0;
        lerr_d  = 1'b1;
      end
    end else if (step) begin
      if (tc) begin
        ovf_d = 1'b1;
        if (SATURATE == MODE_WRAP) begin
          count_d = up ? '0 : MAX_VAL;
          wrap_d  = 1'b1;
        end
      end else begin
        count_d = up ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      lerr_q  <= lerr_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign ovf      = ovf_q;
  assign load_err = lerr_q;

endmodule

// File: tb/tb_sync_updown_counter_mod.sv
// tb/tb_sync_updown_counter_mod.sv - self-checking bench for sync_updown_counter_mod
module tb_sync_updown_counter_mod;

  // Instances: 0 default, 1 mod-10, 2 mod-10 saturating, 3 prescale-3, 4/5 BCD cascade lo/hi
  localparam int MOD_C [6] = '{16, 10, 10, 16, 10, 10};
  localparam int SAT_C [6] = '{0, 0, 1, 0, 0, 0};
  localparam int PRE_C [6] = '{1, 1, 1, 3, 1, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1, en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] cnt [6];
  logic       tcv [6], cyv [6], wpv [6], ovv [6], lev [6];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_updown_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(1)) u_def (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .count(cnt[0]), .tc(tcv[0]), .carry(cyv[0]), .wrap(wpv[0]), .ovf(ovv[0]), .load_err(lev[0]));
  sync_updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u_m10 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .count(cnt[1]), .tc(tcv[1]), .carry(cyv[1]), .wrap(wpv[1]), .ovf(ovv[1]), .load_err(lev[1]));
  sync_updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .count(cnt[2]), .tc(tcv[2]), .carry(cyv[2]), .wrap(wpv[2]), .ovf(ovv[2]), .load_err(lev[2]));
  sync_updown_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(3)) u_ps (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .count(cnt[3]), .tc(tcv[3]), .carry(cyv[3]), .wrap(wpv[3]), .ovf(ovv[3]), .load_err(lev[3]));
  sync_updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u_lo (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .count(cnt[4]), .tc(tcv[4]), .carry(cyv[4]), .wrap(wpv[4]), .ovf(ovv[4]), .load_err(lev[4]));
  sync_updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u_hi (
    .clk(clk), .rst(rst), .en(cyv[4]), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .count(cnt[5]), .tc(tcv[5]), .carry(cyv[5]), .wrap(wpv[5]), .ovf(ovv[5]), .load_err(lev[5]));

  typedef struct {
    int count;
    int ps;
    bit wrap;
    bit ovf;
    bit lerr;
  } mstate_t;

  mstate_t m [6];
  mstate_t nxt [6];

  function automatic bit m_tc(mstate_t s, int modv, bit dir);
    return dir ? (s.count == modv - 1) : (s.count == 0);
  endfunction

  function automatic bit m_step(mstate_t s, int pre, bit e);
    return e && (s.ps == pre - 1);
  endfunction

  function automatic mstate_t m_next(mstate_t s, int modv, bit sat, int pre,
                                     bit r, bit e, bit dir, bit c, bit l, int lv);
    mstate_t n;
    n = s;
    n.wrap = 0;
    n.lerr = 0;
    if (r) begin
      n = '{0, 0, 0, 0, 0};
    end else if (c) begin
      n.count = 0; n.ps = 0; n.ovf = 0;
    end else if (l) begin
      n.ps = 0;
      if (lv < modv) n.count = lv;
      else begin n.count = 0; n.lerr = 1; end
    end else if (e) begin
      if (s.ps == pre - 1) begin
        n.ps = 0;
        if (m_tc(s, modv, dir)) begin
          n.ovf = 1;
          if (!sat) begin
            n.count = dir ? 0 : modv - 1;
            n.wrap = 1;
          end
        end else begin
          n.count = dir ? s.count + 1 : s.count - 1;
        end
      end else begin
        n.ps = s.ps + 1;
      end
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; up = 1'b1; clr = 1'b0; load = 1'b0;
    tick(); tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cnt[i] !== 4'd0 || wpv[i] !== 1'b0 || ovv[i] !== 1'b0 || lev[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: count=%0d wrap=%b ovf=%b load_err=%b, required 0/0/0/0",
                 i, cnt[i], wpv[i], ovv[i], lev[i]);
      end
    end
  endtask

  task automatic test_up_default();
    rst = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    for (int i = 0; i <= 16; i++) begin
      checks++;
      if (cnt[0] !== 4'(i % 16) || tcv[0] !== (i == 15) || wpv[0] !== (i == 16) ||
          ovv[0] !== (i == 16)) begin
        errors++;
        $display("FAIL up_default[%0d]: count=%0d tc=%b wrap=%b ovf=%b, required %0d/%b/%b/%b",
                 i, cnt[0], tcv[0], wpv[0], ovv[0], i % 16, i == 15, i == 16, i == 16);
      end
      if (i < 16) tick();
    end
  endtask

  task automatic test_mod_down();
    int exp;
    en = 1'b0; load = 1'b1; load_val = 4'd3;
    tick();
    load = 1'b0; up = 1'b0; en = 1'b1;
    #1;
    for (int j = 0; j < 6; j++) begin
      exp = (13 - j) % 10;
      checks++;
      if (cnt[1] !== 4'(exp) || cyv[1] !== (exp == 0) || wpv[1] !== (j == 4)) begin
        errors++;
        $display("FAIL mod_down[%0d]: count=%0d carry=%b wrap=%b, required %0d/%b/%b",
                 j, cnt[1], cyv[1], wpv[1], exp, exp == 0, j == 4);
      end
      if (j < 5) tick();
    end
  endtask

  task automatic test_saturate();
    int exp;
    en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; load = 1'b1; load_val = 4'd7;
    tick();
    load = 1'b0; up = 1'b1; en = 1'b1;
    for (int j = 0; j < 5; j++) begin
      exp = (7 + j > 9) ? 9 : 7 + j;
      checks++;
      if (cnt[2] !== 4'(exp) || ovv[2] !== (j >= 3) || wpv[2] !== 1'b0) begin
        errors++;
        $display("FAIL saturate[%0d]: count=%0d ovf=%b wrap=%b, required %0d/%b/0",
                 j, cnt[2], ovv[2], wpv[2], exp, j >= 3);
      end
      if (j < 4) tick();
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (cnt[2] !== 4'd0 || ovv[2] !== 1'b0) begin
      errors++;
      $display("FAIL saturate_clr: count=%0d ovf=%b, required 0/0", cnt[2], ovv[2]);
    end
  endtask

  task automatic test_prescaler();
    en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (cnt[3] !== 4'(k / 3)) begin
        errors++;
        $display("FAIL prescale_run[%0d]: count=%0d, required %0d", k, cnt[3], k / 3);
      end
    end
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (cnt[3] !== 4'd3) begin
        errors++;
        $display("FAIL prescale_hold[%0d]: count=%0d, required 3", k, cnt[3]);
      end
    end
    en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (cnt[3] !== ((k == 3) ? 4'd4 : 4'd3)) begin
        errors++;
        $display("FAIL prescale_resume[%0d]: count=%0d, required %0d", k, cnt[3], (k == 3) ? 4 : 3);
      end
    end
  endtask

  task automatic test_priority();
    en = 1'b0; up = 1'b1; load = 1'b1; load_val = 4'd12;
    tick();
    checks++;
    if (cnt[1] !== 4'd0 || lev[1] !== 1'b1) begin
      errors++;
      $display("FAIL illegal_load: count=%0d load_err=%b, required 0/1", cnt[1], lev[1]);
    end
    load_val = 4'd4;
    tick();
    checks++;
    if (cnt[1] !== 4'd4 || lev[1] !== 1'b0) begin
      errors++;
      $display("FAIL legal_load: count=%0d load_err=%b, required 4/0", cnt[1], lev[1]);
    end
    clr = 1'b1; load_val = 4'd5;
    tick();
    checks++;
    if (cnt[1] !== 4'd0 || lev[1] !== 1'b0) begin
      errors++;
      $display("FAIL clr_over_load: count=%0d load_err=%b, required 0/0", cnt[1], lev[1]);
    end
    clr = 1'b0; load_val = 4'd9;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    checks++;
    if (cnt[1] !== 4'd0 || wpv[1] !== 1'b1 || ovv[1] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_before_rst: count=%0d wrap=%b ovf=%b, required 0/1/1", cnt[1], wpv[1], ovv[1]);
    end
    rst = 1'b1; load = 1'b1; load_val = 4'd12;
    tick();
    checks++;
    if (cnt[1] !== 4'd0 || wpv[1] !== 1'b0 || ovv[1] !== 1'b0 || lev[1] !== 1'b0) begin
      errors++;
      $display("FAIL rst_over_load: count=%0d wrap=%b ovf=%b load_err=%b, required 0/0/0/0",
               cnt[1], wpv[1], ovv[1], lev[1]);
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_cascade();
    int wraps;
    int val;
    rst = 1'b1; clr = 1'b0; load = 1'b0;
    tick();
    rst = 1'b0; en = 1'b1; up = 1'b1;
    wraps = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      val = int'(cnt[5]) * 10 + int'(cnt[4]);
      if (wpv[5]) wraps++;
      checks++;
      if (val !== k % 100) begin
        errors++;
        $display("FAIL cascade[%0d]: value=%0d, required %0d", k, val, k % 100);
      end
    end
    checks++;
    if (wraps !== 1) begin
      errors++;
      $display("FAIL cascade_wraps: upper wrap pulses=%0d, required 1", wraps);
    end
  endtask

  task automatic test_random();
    bit e_i, exp_tc, exp_cy;
    rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) m[i] = '{0, 0, 0, 0, 0};
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 49) == 0);
      clr      = ($urandom_range(0, 15) == 0);
      load     = ($urandom_range(0, 7) == 0);
      load_val = 4'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      up       = 1'($urandom_range(0, 1));
      #1;
      for (int i = 0; i < 6; i++) begin
        e_i    = (i == 5) ? (m_step(m[4], PRE_C[4], en) && m_tc(m[4], MOD_C[4], up)) : en;
        exp_tc = m_tc(m[i], MOD_C[i], up);
        exp_cy = m_step(m[i], PRE_C[i], e_i) && exp_tc;
        checks++;
        if (tcv[i] !== exp_tc || cyv[i] !== exp_cy) begin
          errors++;
          $display("FAIL random_comb[%0d] n=%0d: tc=%b carry=%b, required %b/%b",
                   i, n, tcv[i], cyv[i], exp_tc, exp_cy);
        end
        nxt[i] = m_next(m[i], MOD_C[i], SAT_C[i] != 0, PRE_C[i], rst, e_i, up, clr, load,
                        int'(load_val));
      end
      tick();
      for (int i = 0; i < 6; i++) begin
        m[i] = nxt[i];
        checks++;
        if (cnt[i] !== 4'(m[i].count) || wpv[i] !== m[i].wrap || ovv[i] !== m[i].ovf ||
            lev[i] !== m[i].lerr) begin
          errors++;
          $display("FAIL random_reg[%0d] n=%0d: count=%0d wrap=%b ovf=%b load_err=%b, required %0d/%b/%b/%b",
                   i, n, cnt[i], wpv[i], ovv[i], lev[i], m[i].count, m[i].wrap, m[i].ovf, m[i].lerr);
        end
      end
    end
    rst = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_up_default();
    test_mod_down();
    test_saturate();
    test_prescaler();
    test_priority();
    test_cascade();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
